// File: rtl/jc_stack_unit_if.sv
// jc_stack_unit_if: program-memory/decode/PC-mux signals of the jump-control unit
interface jc_stack_unit_if #(parameter int AW = 16, parameter int FW = 2, parameter int DEPTH = 4);
  localparam int SW = $clog2(DEPTH + 1);
  logic [AW-1:0] jmp_address_pm;
  logic [AW-1:0] current_address;
  logic [5:0]    op;
  logic [FW-1:0] flag_ex;
  logic          interrupt;
  logic [AW-1:0] jmp_loc;
  logic          pc_mux_sel;
  logic [FW-1:0] flag_restore;
  logic          flag_restore_vld;
  logic          int_ack;
  logic          int_dropped;
  logic          ret_err;
  logic [SW-1:0] depth;
  modport master (
    output jmp_address_pm, current_address, op, flag_ex, interrupt,
    input  jmp_loc, pc_mux_sel, flag_restore, flag_restore_vld, int_ack, int_dropped, ret_err, depth
  );
  modport slave (
    input  jmp_address_pm, current_address, op, flag_ex, interrupt,
    output jmp_loc, pc_mux_sel, flag_restore, flag_restore_vld, int_ack, int_dropped, ret_err, depth
  );
endinterface

// File: rtl/jc_stack_unit.sv
// jc_stack_unit: jump/RET resolution and interrupt vectoring with a DEPTH-entry return stack.
// Optional CALL opcode enabled by defining JC_CALL_EN.
module jc_stack_unit #(
  parameter int AW = 16,
  parameter int FW = 2,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] VECTOR = 16'hF000
) (
  input logic clk,
  input logic reset,
  jc_stack_unit_if.slave bus
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [5:0] OP_JMP = 6'b011000, OP_RET = 6'b010000, OP_JV = 6'b011100,
                         OP_JNV = 6'b011101, OP_JZ = 6'b011110, OP_JNZ = 6'b011111,
                         OP_CALL = 6'b011001;
  typedef enum logic [1:0] {IDLE, VEC, CAPT} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr_q [DEPTH];
  logic [FW-1:0] flag_q [DEPTH];
  logic [SW-1:0] sp;
  logic [IW-1:0] top, wr;
  logic pending, full, empty, is_ret, is_call, req, accept, drop, pop, call_push, jump;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? VEC : IDLE;
      VEC:  state_nx = CAPT;
      default: state_nx = IDLE;
    endcase
  end
  // RET/CALL are swallowed while the vector override is on the PC mux
  always_comb begin
    full = sp == SW'(DEPTH);
    empty = sp == '0;
    top = IW'(sp - SW'(1));
    wr = IW'(sp);
    is_ret = bus.op == OP_RET && state != VEC;
`ifdef JC_CALL_EN
    is_call = bus.op == OP_CALL && state != VEC;
`else
    is_call = 1'b0;
`endif
    req = bus.interrupt | pending;
    accept = reset && state == IDLE && req && !is_ret && !is_call && !full;
    drop = reset && state == IDLE && req && !is_ret && !is_call && full;
    pop = reset && is_ret && !empty;
    call_push = reset && is_call && !full;
    jump = bus.op == OP_JMP || (bus.op == OP_JV && bus.flag_ex[0]) || (bus.op == OP_JNV && !bus.flag_ex[0]) ||
           (bus.op == OP_JZ && bus.flag_ex[1]) || (bus.op == OP_JNZ && !bus.flag_ex[1]);
  end
  always_comb begin
    bus.pc_mux_sel = state == VEC || pop || is_call || jump;
    bus.jmp_loc = state == VEC ? VECTOR : pop ? addr_q[top] : bus.jmp_address_pm;
    bus.flag_restore = pop ? flag_q[top] : '0;
    bus.flag_restore_vld = pop;
    bus.int_ack = accept;
    bus.int_dropped = drop || (reset && is_call && full);
    bus.ret_err = reset && is_ret && empty;
    bus.depth = sp;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      sp <= '0;
      pending <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        flag_q[i] <= '0;
      end
    end else begin
      pending <= !(accept || drop) && (pending || bus.interrupt);
      if (accept || call_push) begin
        addr_q[wr] <= bus.current_address + AW'(1);
        flag_q[wr] <= accept ? '0 : bus.flag_ex;
      end
      if (state == CAPT && !pop) flag_q[top] <= bus.flag_ex;
      sp <= sp + SW'(accept || call_push) - SW'(pop);
    end
endmodule

// File: tb/tb_jc_stack_unit.sv
// tb_jc_stack_unit: directed vector table for jump decode plus hand sequences for the stack/interrupt paths
module tb_jc_stack_unit;
  localparam logic [5:0] NOP = 6'b000000, JMP = 6'b011000, RET = 6'b010000, JV = 6'b011100,
                         JNV = 6'b011101, JZ = 6'b011110, JNZ = 6'b011111, CALL = 6'b011001;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  jc_stack_unit_if #(.AW(16), .FW(2), .DEPTH(4)) bus ();
  jc_stack_unit #(.AW(16), .FW(2), .DEPTH(4), .VECTOR(16'hF000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0]  op;
    logic [1:0]  fl;
    logic [15:0] ja;
    logic        sel;
  } vec_t;
  vec_t vt [10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [5:0] op, input logic [15:0] ca, input logic irq);
    bus.op = op;
    bus.current_address = ca;
    bus.interrupt = irq;
    #1;
  endtask
  // full interrupt sequence from IDLE; ends one cycle into the following IDLE
  task automatic do_int(input logic [15:0] ca, input logic [1:0] fl, input string nm);
    drive(NOP, ca, 1'b1);
    chk({nm, "_ack"}, 32'(bus.int_ack), 32'd1);
    tick;
    drive(JMP, ca, 1'b0);
    chk({nm, "_vec_sel"}, 32'(bus.pc_mux_sel), 32'd1);
    chk({nm, "_vec_loc"}, 32'(bus.jmp_loc), 32'hF000);
    tick;
    bus.flag_ex = fl;
    drive(NOP, ca, 1'b0);
    tick;
    bus.flag_ex = 2'b00;
  endtask
  task automatic do_ret(input logic [15:0] loc, input logic [1:0] fl, input string nm);
    drive(RET, 16'h0, 1'b0);
    chk({nm, "_sel"}, 32'(bus.pc_mux_sel), 32'd1);
    chk({nm, "_loc"}, 32'(bus.jmp_loc), 32'(loc));
    chk({nm, "_flag"}, 32'(bus.flag_restore), 32'(fl));
    chk({nm, "_vld"}, 32'(bus.flag_restore_vld), 32'd1);
    tick;
  endtask
  initial begin
    vt[0] = '{JZ,  2'b10, 16'h0040, 1'b1};
    vt[1] = '{JNZ, 2'b10, 16'h0040, 1'b0};
    vt[2] = '{JMP, 2'b00, 16'h1234, 1'b1};
    vt[3] = '{JV,  2'b01, 16'h2000, 1'b1};
    vt[4] = '{JV,  2'b10, 16'h2000, 1'b0};
    vt[5] = '{JNV, 2'b00, 16'h3000, 1'b1};
    vt[6] = '{JNV, 2'b01, 16'h3000, 1'b0};
    vt[7] = '{JZ,  2'b01, 16'h4000, 1'b0};
    vt[8] = '{JNZ, 2'b01, 16'h5000, 1'b1};
    vt[9] = '{NOP, 2'b11, 16'h6000, 1'b0};
    bus.jmp_address_pm = 16'h0;
    bus.flag_ex = 2'b00;
    drive(NOP, 16'h0, 1'b0);
    tick;
    tick;
    chk("rst_depth", 32'(bus.depth), 32'd0);
    chk("rst_ack", 32'(bus.int_ack), 32'd0);
    chk("rst_vld", 32'(bus.flag_restore_vld), 32'd0);
    chk("rst_sel", 32'(bus.pc_mux_sel), 32'd0);
    reset = 1'b1;
    tick;
    foreach (vt[i]) begin
      bus.flag_ex = vt[i].fl;
      bus.jmp_address_pm = vt[i].ja;
      drive(vt[i].op, 16'h0, 1'b0);
      chk($sformatf("vec%0d_sel", i), 32'(bus.pc_mux_sel), 32'(vt[i].sel));
      chk($sformatf("vec%0d_loc", i), 32'(bus.jmp_loc), 32'(vt[i].ja));
      tick;
    end
    bus.flag_ex = 2'b00;
    bus.jmp_address_pm = 16'h0555;
    // single interrupt then RET
    do_int(16'h0123, 2'b01, "t2");
    chk("t2_depth", 32'(bus.depth), 32'd1);
    do_ret(16'h0124, 2'b01, "t2_ret");
    drive(NOP, 16'h0, 1'b0);
    chk("t2_depth0", 32'(bus.depth), 32'd0);
    chk("t2_vld0", 32'(bus.flag_restore_vld), 32'd0);
    // fill the stack, fifth request is dropped
    for (int i = 0; i < 4; i++) do_int(16'h0100 + 16'(i), 2'(i), $sformatf("t3_int%0d", i));
    chk("t3_depth4", 32'(bus.depth), 32'd4);
    drive(NOP, 16'h0777, 1'b1);
    chk("t3_ack5", 32'(bus.int_ack), 32'd0);
    chk("t3_drop", 32'(bus.int_dropped), 32'd1);
    tick;
    drive(NOP, 16'h0, 1'b0);
    chk("t3_idle_sel", 32'(bus.pc_mux_sel), 32'd0);
    chk("t3_drop_clr", 32'(bus.int_dropped), 32'd0);
    chk("t3_no_pend", 32'(bus.int_ack), 32'd0);
    chk("t3_depth_hold", 32'(bus.depth), 32'd4);
    for (int i = 3; i >= 0; i--) do_ret(16'h0101 + 16'(i), 2'(i), $sformatf("t3_ret%0d", i));
    drive(NOP, 16'h0, 1'b0);
    chk("t3_depth0", 32'(bus.depth), 32'd0);
    // RET on empty stack, then RET + interrupt together
    drive(RET, 16'h0, 1'b0);
    chk("t4_err", 32'(bus.ret_err), 32'd1);
    chk("t4_err_sel", 32'(bus.pc_mux_sel), 32'd0);
    tick;
    drive(NOP, 16'h0, 1'b0);
    chk("t4_err_clr", 32'(bus.ret_err), 32'd0);
    chk("t4_err_depth", 32'(bus.depth), 32'd0);
    do_int(16'h0200, 2'b11, "t4_int");
    drive(RET, 16'h0, 1'b1);
    chk("t4_both_sel", 32'(bus.pc_mux_sel), 32'd1);
    chk("t4_both_loc", 32'(bus.jmp_loc), 32'h0201);
    chk("t4_both_flag", 32'(bus.flag_restore), 32'd3);
    chk("t4_both_noack", 32'(bus.int_ack), 32'd0);
    tick;
    drive(NOP, 16'h0300, 1'b0);
    chk("t4_late_ack", 32'(bus.int_ack), 32'd1);
    chk("t4_late_depth", 32'(bus.depth), 32'd0);
    tick;
    // RET during VEC is ignored; interrupt during VEC becomes pending
    drive(RET, 16'h0, 1'b1);
    chk("t4_vec_ret_loc", 32'(bus.jmp_loc), 32'hF000);
    chk("t4_vec_ret_err", 32'(bus.ret_err), 32'd0);
    chk("t4_vec_ret_vld", 32'(bus.flag_restore_vld), 32'd0);
    tick;
    bus.flag_ex = 2'b10;
    drive(NOP, 16'h0, 1'b0);
    chk("t4_capt_ack", 32'(bus.int_ack), 32'd0);
    tick;
    bus.flag_ex = 2'b00;
    drive(NOP, 16'h0400, 1'b0);
    chk("t4_pend_ack", 32'(bus.int_ack), 32'd1);
    chk("t4_pend_depth", 32'(bus.depth), 32'd1);
    tick;
    tick;
    bus.flag_ex = 2'b01;
    tick;
    bus.flag_ex = 2'b00;
    chk("t4_depth2", 32'(bus.depth), 32'd2);
    do_ret(16'h0401, 2'b01, "t4_ret_b");
    do_ret(16'h0301, 2'b10, "t4_ret_a");
    // address wrap, then reset during VEC
    do_int(16'hFFFF, 2'b00, "t5_wrap");
    do_ret(16'h0000, 2'b00, "t5_wrap_ret");
    drive(NOP, 16'h0050, 1'b1);
    chk("t5_ack", 32'(bus.int_ack), 32'd1);
    tick;
    reset = 1'b0;
    drive(NOP, 16'h0, 1'b0);
    chk("t5_vec_sel", 32'(bus.pc_mux_sel), 32'd1);
    tick;
    reset = 1'b1;
    drive(NOP, 16'h0, 1'b0);
    chk("t5_rst_depth", 32'(bus.depth), 32'd0);
    chk("t5_rst_idle", 32'(bus.pc_mux_sel), 32'd0);
    drive(RET, 16'h0, 1'b0);
    chk("t5_rst_empty", 32'(bus.ret_err), 32'd1);
    tick;
`ifdef JC_CALL_EN
    bus.flag_ex = 2'b10;
    bus.jmp_address_pm = 16'h0200;
    drive(CALL, 16'h0010, 1'b0);
    chk("t6_call_sel", 32'(bus.pc_mux_sel), 32'd1);
    chk("t6_call_loc", 32'(bus.jmp_loc), 32'h0200);
    tick;
    bus.flag_ex = 2'b00;
    drive(NOP, 16'h0, 1'b0);
    chk("t6_call_depth", 32'(bus.depth), 32'd1);
    do_ret(16'h0011, 2'b10, "t6_ret");
`else
    bus.jmp_address_pm = 16'h0200;
    drive(CALL, 16'h0010, 1'b0);
    chk("t6_nocall_sel", 32'(bus.pc_mux_sel), 32'd0);
    tick;
    drive(NOP, 16'h0, 1'b0);
    chk("t6_nocall_depth", 32'(bus.depth), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
